// File: rtl/wb_port_arbiter_if.sv
// Writeback arbitration bus: result-source requests in, registered writeback ports out.
// The arbiter attaches through the slave modport; the result sources use master.
interface wb_port_arbiter_if #(
    parameter int NUM_REQ  = 6,
    parameter int NUM_PORT = 4,
    parameter int WB_W     = 64
);
    logic                     i_flush;
    logic [NUM_REQ-1:0]       i_req_vld;
    logic [NUM_REQ-1:0]       i_req_fixed;
    logic [NUM_REQ*WB_W-1:0]  i_req_info;
    logic [NUM_REQ-1:0]       o_req_rdy;
    logic [NUM_PORT-1:0]      o_wb_vld;
    logic [NUM_PORT*WB_W-1:0] o_wbInfo;
    logic                     o_conflict;

    modport master (
        output i_flush, i_req_vld, i_req_fixed, i_req_info,
        input  o_req_rdy, o_wb_vld, o_wbInfo, o_conflict
    );

    modport slave (
        input  i_flush, i_req_vld, i_req_fixed, i_req_info,
        output o_req_rdy, o_wb_vld, o_wbInfo, o_conflict
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares NUM_PORT writeback ports among NUM_REQ result sources: fixed-latency sources win
// in index order, stallable sources take leftover ports round-robin; results registered.
module wb_port_arbiter #(
    parameter int NUM_REQ  = 6,
    parameter int NUM_PORT = 4,
    parameter int WB_W     = 64
) (
    input  logic                clk,
    input  logic                rst,
    wb_port_arbiter_if.slave    bus
);
    localparam int SW = (NUM_REQ  > 1) ? $clog2(NUM_REQ)  : 1;
    localparam int PI = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam int CW = $clog2(NUM_REQ + NUM_PORT + 1);

    logic [SW-1:0]        rr_ptr;
    logic [SW-1:0]        rr_next;
    logic [SW-1:0]        sel       [NUM_PORT];
    logic [WB_W-1:0]      port_info [NUM_PORT];
    logic [NUM_PORT-1:0]  used;
    logic [NUM_REQ-1:0]   rdy;
    logic                 overflow;
    logic                 p2_any;

    logic [NUM_PORT-1:0]      wb_vld_q;
    logic [NUM_PORT*WB_W-1:0] wb_info_q;
    logic                     conflict_q;

    always_comb begin
        logic [CW-1:0] nfix;
        logic [CW-1:0] nport;
        logic [SW:0]   sum;
        logic [SW-1:0] idx;
        rdy      = '0;
        used     = '0;
        overflow = 1'b0;
        p2_any   = 1'b0;
        rr_next  = rr_ptr;
        nfix     = '0;
        nport    = '0;
        sum      = '0;
        idx      = '0;
        for (int unsigned p = 0; p < NUM_PORT; p++) sel[p] = '0;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.i_req_vld[i] && bus.i_req_fixed[i]) begin
                if (nfix < CW'(NUM_PORT)) begin
                    rdy[i]             = 1'b1;
                    sel[nfix[PI-1:0]]  = SW'(i);
                    used[nfix[PI-1:0]] = 1'b1;
                end
                nfix = nfix + 1'b1;
            end
        end
        overflow = (nfix > CW'(NUM_PORT));
        nport    = nfix;

        // Stallable search starts at rr_ptr and wraps; free ports are filled in search order.
        if (!overflow) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                sum = {1'b0, rr_ptr} + (SW+1)'(k);
                if (sum >= (SW+1)'(NUM_REQ)) sum = sum - (SW+1)'(NUM_REQ);
                idx = sum[SW-1:0];
                if (bus.i_req_vld[idx] && !bus.i_req_fixed[idx] && nport < CW'(NUM_PORT)) begin
                    rdy[idx]            = 1'b1;
                    sel[nport[PI-1:0]]  = idx;
                    used[nport[PI-1:0]] = 1'b1;
                    nport   = nport + 1'b1;
                    p2_any  = 1'b1;
                    rr_next = (idx == SW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                end
            end
        end

        if (!rst || bus.i_flush) begin
            rdy    = '0;
            used   = '0;
            p2_any = 1'b0;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORT; p++) begin
            port_info[p] = '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (sel[p] == SW'(i)) port_info[p] = bus.i_req_info[i*WB_W +: WB_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_vld_q   <= '0;
            wb_info_q  <= '0;
            conflict_q <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            if (overflow) conflict_q <= 1'b1;
            wb_vld_q <= used;
            for (int unsigned p = 0; p < NUM_PORT; p++) begin
                if (used[p]) wb_info_q[p*WB_W +: WB_W] <= port_info[p];
            end
            if (p2_any) rr_ptr <= rr_next;
        end
    end

    assign bus.o_req_rdy  = rdy;
    assign bus.o_wb_vld   = wb_vld_q;
    assign bus.o_wbInfo   = wb_info_q;
    assign bus.o_conflict = conflict_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, fixed priority, round-robin, mixed,
// overflow, flush and a randomised grant/payload scoreboard.
module tb_wb_port_arbiter;
    localparam int NUM_REQ  = 6;
    localparam int NUM_PORT = 4;
    localparam int WB_W     = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_PORT(NUM_PORT), .WB_W(WB_W)) bus();

    wb_port_arbiter #(.NUM_REQ(NUM_REQ), .NUM_PORT(NUM_PORT), .WB_W(WB_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int unsigned tag = 0;
    logic [WB_W-1:0] info_q [NUM_REQ];

    task automatic refresh(input int k);
        tag++;
        info_q[k] = {16'hC0DE, 16'(k), 32'(tag)};
    endtask

    task automatic set_req(input logic [NUM_REQ-1:0] vld, input logic [NUM_REQ-1:0] fixed,
                           input logic flush);
        @(negedge clk);
        bus.i_req_vld   = vld;
        bus.i_req_fixed = fixed;
        bus.i_flush     = flush;
        for (int k = 0; k < NUM_REQ; k++) bus.i_req_info[k*WB_W +: WB_W] = info_q[k];
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_req('1, '1, 1'b0);
        checks++;
        if (bus.o_req_rdy !== 6'b0) begin
            errors++; $display("FAIL reset_rdy0: got %b expected %b", bus.o_req_rdy, 6'b0);
        end
        @(posedge clk);
        set_req('1, '1, 1'b0);
        checks++;
        if (bus.o_req_rdy !== 6'b0) begin
            errors++; $display("FAIL reset_rdy1: got %b expected %b", bus.o_req_rdy, 6'b0);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.o_wb_vld !== 4'b0) begin
            errors++; $display("FAIL reset_wb_vld: got %b expected %b", bus.o_wb_vld, 4'b0);
        end
        checks++;
        if (bus.o_conflict !== 1'b0) begin
            errors++; $display("FAIL reset_conflict: got %b expected 0", bus.o_conflict);
        end
        set_req('0, '0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_only();
        logic [WB_W-1:0] e0, e1;
        set_req(6'b000011, 6'b000011, 1'b0);
        e0 = info_q[0];
        e1 = info_q[1];
        checks++;
        if (bus.o_req_rdy !== 6'b000011) begin
            errors++; $display("FAIL fixed_rdy: got %b expected %b", bus.o_req_rdy, 6'b000011);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.o_wb_vld !== 4'b0011) begin
            errors++; $display("FAIL fixed_wb_vld: got %b expected %b", bus.o_wb_vld, 4'b0011);
        end
        checks++;
        if (bus.o_wbInfo[0 +: WB_W] !== e0) begin
            errors++; $display("FAIL fixed_port0: got %h expected %h", bus.o_wbInfo[0 +: WB_W], e0);
        end
        checks++;
        if (bus.o_wbInfo[WB_W +: WB_W] !== e1) begin
            errors++; $display("FAIL fixed_port1: got %h expected %h", bus.o_wbInfo[WB_W +: WB_W], e1);
        end
        refresh(0);
        refresh(1);
    endtask

    // Runs a table of cycles where every port is expected to be filled.
    task automatic run_full_table(input string name, input int n,
                                  input logic [NUM_REQ-1:0] vld [8],
                                  input logic [NUM_REQ-1:0] fixed [8],
                                  input logic [NUM_REQ-1:0] exp_rdy [8],
                                  input int src [8][NUM_PORT]);
        logic [WB_W-1:0] e [NUM_PORT];
        for (int c = 0; c < n; c++) begin
            set_req(vld[c], fixed[c], 1'b0);
            for (int p = 0; p < NUM_PORT; p++) e[p] = info_q[src[c][p]];
            checks++;
            if (bus.o_req_rdy !== exp_rdy[c]) begin
                errors++; $display("FAIL %s_rdy[%0d]: got %b expected %b", name, c, bus.o_req_rdy, exp_rdy[c]);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.o_wb_vld !== 4'b1111) begin
                errors++; $display("FAIL %s_wb_vld[%0d]: got %b expected 1111", name, c, bus.o_wb_vld);
            end
            for (int p = 0; p < NUM_PORT; p++) begin
                checks++;
                if (bus.o_wbInfo[p*WB_W +: WB_W] !== e[p]) begin
                    errors++; $display("FAIL %s_port%0d[%0d]: got %h expected %h", name, p, c,
                                       bus.o_wbInfo[p*WB_W +: WB_W], e[p]);
                end
            end
            for (int k = 0; k < NUM_REQ; k++) if (exp_rdy[c][k]) refresh(k);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] vld [8];
        logic [NUM_REQ-1:0] fixed [8];
        logic [NUM_REQ-1:0] rdy [8];
        int src [8][NUM_PORT];
        vld   = '{6'b111100, 6'b111100, 6'b111100, 6'b111111, 6'b111111, 6'b111111, 6'b0, 6'b0};
        fixed = '{default: 6'b0};
        rdy   = '{6'b111100, 6'b111100, 6'b111100, 6'b001111, 6'b110011, 6'b111100, 6'b0, 6'b0};
        src   = '{'{2,3,4,5}, '{2,3,4,5}, '{2,3,4,5}, '{0,1,2,3}, '{4,5,0,1}, '{2,3,4,5},
                  '{0,0,0,0}, '{0,0,0,0}};
        run_full_table("rr", 6, vld, fixed, rdy, src);
    endtask

    task automatic test_mixed();
        logic [NUM_REQ-1:0] vld [8];
        logic [NUM_REQ-1:0] fixed [8];
        logic [NUM_REQ-1:0] rdy [8];
        int src [8][NUM_PORT];
        vld   = '{default: 6'b111111};
        fixed = '{default: 6'b000011};
        rdy   = '{6'b001111, 6'b110011, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
        src   = '{'{0,1,2,3}, '{0,1,4,5}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0},
                  '{0,0,0,0}, '{0,0,0,0}};
        run_full_table("mixed", 2, vld, fixed, rdy, src);
    endtask

    task automatic test_flush();
        logic [WB_W-1:0] e2;
        logic [WB_W-1:0] e [NUM_PORT];
        int order [NUM_PORT] = '{3, 4, 5, 0};
        set_req(6'b000100, 6'b0, 1'b0);
        e2 = info_q[2];
        checks++;
        if (bus.o_req_rdy !== 6'b000100) begin
            errors++; $display("FAIL flush_pre_rdy: got %b expected %b", bus.o_req_rdy, 6'b000100);
        end
        @(posedge clk); #1;
        refresh(2);
        set_req(6'b111111, 6'b0, 1'b1);
        checks++;
        if (bus.o_req_rdy !== 6'b0) begin
            errors++; $display("FAIL flush_rdy: got %b expected %b", bus.o_req_rdy, 6'b0);
        end
        checks++;
        if (bus.o_wb_vld !== 4'b0001 || bus.o_wbInfo[0 +: WB_W] !== e2) begin
            errors++; $display("FAIL flush_cycle_out: got vld %b port0 %h expected vld 0001 port0 %h",
                               bus.o_wb_vld, bus.o_wbInfo[0 +: WB_W], e2);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.o_wb_vld !== 4'b0) begin
            errors++; $display("FAIL flush_wb_vld: got %b expected 0000", bus.o_wb_vld);
        end
        set_req(6'b111111, 6'b0, 1'b0);
        for (int p = 0; p < NUM_PORT; p++) e[p] = info_q[order[p]];
        checks++;
        if (bus.o_req_rdy !== 6'b111001) begin
            errors++; $display("FAIL flush_rr_rdy: got %b expected %b", bus.o_req_rdy, 6'b111001);
        end
        @(posedge clk); #1;
        for (int p = 0; p < NUM_PORT; p++) begin
            checks++;
            if (bus.o_wb_vld[p] !== 1'b1 || bus.o_wbInfo[p*WB_W +: WB_W] !== e[p]) begin
                errors++; $display("FAIL flush_rr_port%0d: got vld %b data %h expected vld 1 data %h",
                                   p, bus.o_wb_vld[p], bus.o_wbInfo[p*WB_W +: WB_W], e[p]);
            end
        end
        for (int p = 0; p < NUM_PORT; p++) refresh(order[p]);
        set_req('0, '0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [WB_W-1:0] e [NUM_PORT];
        set_req(6'b011111, 6'b011111, 1'b0);
        for (int p = 0; p < NUM_PORT; p++) e[p] = info_q[p];
        checks++;
        if (bus.o_req_rdy !== 6'b001111) begin
            errors++; $display("FAIL ovf_rdy: got %b expected %b", bus.o_req_rdy, 6'b001111);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.o_conflict !== 1'b1) begin
            errors++; $display("FAIL ovf_conflict: got %b expected 1", bus.o_conflict);
        end
        for (int p = 0; p < NUM_PORT; p++) begin
            checks++;
            if (bus.o_wb_vld[p] !== 1'b1 || bus.o_wbInfo[p*WB_W +: WB_W] !== e[p]) begin
                errors++; $display("FAIL ovf_port%0d: got vld %b data %h expected vld 1 data %h",
                                   p, bus.o_wb_vld[p], bus.o_wbInfo[p*WB_W +: WB_W], e[p]);
            end
        end
        for (int p = 0; p < NUM_PORT; p++) refresh(p);
        set_req(6'b111111, 6'b011111, 1'b0);
        checks++;
        if (bus.o_req_rdy !== 6'b001111) begin
            errors++; $display("FAIL ovf_no_p2_rdy: got %b expected %b", bus.o_req_rdy, 6'b001111);
        end
        @(posedge clk); #1;
        for (int p = 0; p < NUM_PORT; p++) refresh(p);
        for (int c = 0; c < 3; c++) begin
            set_req('0, '0, 1'b0);
            @(posedge clk); #1;
            checks++;
            if (bus.o_conflict !== 1'b1 || bus.o_wb_vld !== 4'b0) begin
                errors++; $display("FAIL ovf_sticky[%0d]: got conflict %b vld %b expected conflict 1 vld 0000",
                                   c, bus.o_conflict, bus.o_wb_vld);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.o_conflict !== 1'b0) begin
            errors++; $display("FAIL ovf_cleared: got %b expected 0", bus.o_conflict);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_scoreboard();
        logic [NUM_REQ-1:0] pend = '0;
        logic [NUM_REQ-1:0] vld, fixed, rdy;
        logic fl;
        logic [WB_W-1:0] exp_q [$];
        int nf, hits, expc;
        for (int c = 0; c < 60; c++) begin
            vld   = pend;
            fixed = '0;
            nf    = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    vld[k] = 1'b1;
                    if ($urandom_range(0, 2) == 0 && nf < NUM_PORT) begin
                        fixed[k] = 1'b1;
                        nf++;
                    end
                end
            end
            fl = ($urandom_range(0, 7) == 0);
            set_req(vld, fixed, fl);
            rdy  = bus.o_req_rdy;
            expc = fl ? 0 : (($countones(vld) > NUM_PORT) ? NUM_PORT : $countones(vld));
            checks++;
            if ($countones(rdy) != expc || (rdy & ~vld) != '0 || (!fl && (fixed & ~rdy) != '0)) begin
                errors++; $display("FAIL sb_rdy[%0d]: got rdy %b (vld %b fixed %b flush %b) expected %0d grants",
                                   c, rdy, vld, fixed, fl, expc);
            end
            exp_q.delete();
            for (int k = 0; k < NUM_REQ; k++) if (vld[k] && rdy[k]) exp_q.push_back(info_q[k]);
            @(posedge clk); #1;
            checks++;
            if ($countones(bus.o_wb_vld) != exp_q.size()) begin
                errors++; $display("FAIL sb_count[%0d]: got %0d valid ports expected %0d",
                                   c, $countones(bus.o_wb_vld), exp_q.size());
            end
            foreach (exp_q[j]) begin
                hits = 0;
                for (int p = 0; p < NUM_PORT; p++)
                    if (bus.o_wb_vld[p] && bus.o_wbInfo[p*WB_W +: WB_W] === exp_q[j]) hits++;
                checks++;
                if (hits != 1) begin
                    errors++; $display("FAIL sb_payload[%0d]: payload %h seen %0d times expected 1", c, exp_q[j], hits);
                end
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (vld[k] && rdy[k]) begin
                    refresh(k);
                    pend[k] = 1'b0;
                end else begin
                    pend[k] = vld[k] & ~fixed[k] & ~fl;
                end
            end
        end
        set_req('0, '0, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.i_flush     = 1'b0;
        bus.i_req_vld   = '0;
        bus.i_req_fixed = '0;
        bus.i_req_info  = '0;
        for (int k = 0; k < NUM_REQ; k++) refresh(k);
        test_reset();
        test_fixed_only();
        test_round_robin();
        test_mixed();
        test_flush();
        test_overflow();
        test_scoreboard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
